// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IM request handshake,
// one-entry skid buffer and the IF/ID register. Optional perf counters via IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IF_inPCWRITE,
    input  logic        IF_inIFIDWRITE,
    input  logic        IF_inPCSRC,
    input  logic [31:0] IF_inBADDRESS,
    input  logic [1:0]  IF_inJUMP,
    input  logic [31:0] IF_inJUMPADDRESS,
    input  logic [1:0]  IF_inRJUMP,
    input  logic [31:0] IF_inRJUMPADDRESS,
    input  logic        IM_ACK,
    input  logic [31:0] IM_RDATA,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    output logic [31:0] IFID_ORDER,
    output logic [31:0] IFID_PCADD4,
    output logic        IFID_VALID,
    output logic [31:0] IF_outPC,
    output logic [1:0]  IF_outSTATE
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] IF_outFETCHCNT,
    output logic [31:0] IF_outSTALLCNT
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HELD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] order_q, order_d;
    logic [31:0] pcadd4_q, pcadd4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;
    logic        fetch_load;

    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        advance;

    assign pc_plus4 = pc_q + 32'd4;
    assign advance  = IF_inPCWRITE & IF_inIFIDWRITE;
    assign redirect = IF_inPCWRITE &
                      ((IF_inRJUMP != 2'b00) | (IF_inJUMP != 2'b00) | IF_inPCSRC);

    // Register jump beats direct jump beats branch; targets are forced word aligned.
    always_comb begin
        target_raw = IF_inBADDRESS;
        if (IF_inRJUMP != 2'b00) begin
            target_raw = IF_inRJUMPADDRESS;
        end else if (IF_inJUMP != 2'b00) begin
            target_raw = IF_inJUMPADDRESS;
        end
    end
    assign target = {target_raw[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        order_d    = order_q;
        pcadd4_d   = pcadd4_q;
        valid_d    = valid_q;
        skid_d     = skid_q;
        fetch_load = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d     = target;
                    order_d  = NOP_WORD;
                    pcadd4_d = 32'd0;
                    valid_d  = 1'b0;
                    // A response arriving now belongs to the squashed path.
                    state_d  = IM_ACK ? S_FETCH : S_DRAIN;
                end else if (IM_ACK) begin
                    if (advance) begin
                        order_d    = IM_RDATA;
                        pcadd4_d   = pc_plus4;
                        valid_d    = 1'b1;
                        pc_d       = pc_plus4;
                        fetch_load = 1'b1;
                    end else begin
                        skid_d  = IM_RDATA;
                        state_d = S_HELD;
                    end
                end else if (IF_inIFIDWRITE) begin
                    order_d  = NOP_WORD;
                    pcadd4_d = 32'd0;
                    valid_d  = 1'b0;
                end
            end
            S_HELD: begin
                if (redirect) begin
                    pc_d     = target;
                    order_d  = NOP_WORD;
                    pcadd4_d = 32'd0;
                    valid_d  = 1'b0;
                    state_d  = S_FETCH;
                end else if (advance) begin
                    order_d    = skid_q;
                    pcadd4_d   = pc_plus4;
                    valid_d    = 1'b1;
                    pc_d       = pc_plus4;
                    fetch_load = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                // IF/ID already holds a bubble; only the PC may move here.
                if (redirect) begin
                    pc_d = target;
                end
                if (IM_ACK) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            order_q  <= NOP_WORD;
            pcadd4_q <= 32'd0;
            valid_q  <= 1'b0;
            skid_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            order_q  <= order_d;
            pcadd4_q <= pcadd4_d;
            valid_q  <= valid_d;
            skid_q   <= skid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!IF_inIFIDWRITE) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign IF_outFETCHCNT = fetch_cnt_q;
    assign IF_outSTALLCNT = stall_cnt_q;
`else
    logic unused_fetch_load;
    assign unused_fetch_load = fetch_load;
`endif

    // Request is gated by reset directly so nothing goes out during the reset cycle.
    assign IM_REQ      = RESET & (state_q == S_FETCH);
    assign IM_ADDR     = pc_q;
    assign IFID_ORDER  = order_q;
    assign IFID_PCADD4 = pcadd4_q;
    assign IFID_VALID  = valid_q;
    assign IF_outPC    = pc_q;
    assign IF_outSTATE = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus, queue scoreboard for fetch addresses
// and IF/ID entries checked by an independent negedge monitor.
module tb_if_fetch_stage;

    logic        CLOCK;
    logic        RESET;
    logic        IF_inPCWRITE;
    logic        IF_inIFIDWRITE;
    logic        IF_inPCSRC;
    logic [31:0] IF_inBADDRESS;
    logic [1:0]  IF_inJUMP;
    logic [31:0] IF_inJUMPADDRESS;
    logic [1:0]  IF_inRJUMP;
    logic [31:0] IF_inRJUMPADDRESS;
    logic        IM_ACK;
    logic [31:0] IM_RDATA;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic [31:0] IFID_ORDER;
    logic [31:0] IFID_PCADD4;
    logic        IFID_VALID;
    logic [31:0] IF_outPC;
    logic [1:0]  IF_outSTATE;
`ifdef IF_PERF_CNT_EN
    logic [31:0] IF_outFETCHCNT;
    logic [31:0] IF_outSTALLCNT;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ifid_q[$];

    if_fetch_stage dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .IF_inPCWRITE     (IF_inPCWRITE),
        .IF_inIFIDWRITE   (IF_inIFIDWRITE),
        .IF_inPCSRC       (IF_inPCSRC),
        .IF_inBADDRESS    (IF_inBADDRESS),
        .IF_inJUMP        (IF_inJUMP),
        .IF_inJUMPADDRESS (IF_inJUMPADDRESS),
        .IF_inRJUMP       (IF_inRJUMP),
        .IF_inRJUMPADDRESS(IF_inRJUMPADDRESS),
        .IM_ACK           (IM_ACK),
        .IM_RDATA         (IM_RDATA),
        .IM_REQ           (IM_REQ),
        .IM_ADDR          (IM_ADDR),
        .IFID_ORDER       (IFID_ORDER),
        .IFID_PCADD4      (IFID_PCADD4),
        .IFID_VALID       (IFID_VALID),
        .IF_outPC         (IF_outPC),
        .IF_outSTATE      (IF_outSTATE)
`ifdef IF_PERF_CNT_EN
        ,
        .IF_outFETCHCNT   (IF_outFETCHCNT),
        .IF_outSTALLCNT   (IF_outSTALLCNT)
`endif
    );

    // Clock / reset
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic ack, input logic [31:0] rdata);
        IM_ACK   = ack;
        IM_RDATA = rdata;
        @(posedge CLOCK);
        #1;
        IM_ACK   = 1'b0;
        IM_RDATA = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        exp_addr_q.push_back(addr);
        exp_ifid_q.push_back({word, addr + 32'd4});
        drive(1'b1, word);
    endtask

    task automatic clear_redirects();
        IF_inPCSRC = 1'b0;
        IF_inJUMP  = 2'b00;
        IF_inRJUMP = 2'b00;
    endtask

    // Monitor: checks every accepted request address and every new IF/ID entry.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pcadd4 = 32'h0;
    always @(negedge CLOCK) begin
        if (IM_REQ === 1'b1 && IM_ACK === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_im_handshake", {32'h0, IM_ADDR}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("im_addr", {32'h0, IM_ADDR}, {32'h0, exp_addr_q.pop_front()});
            end
        end
        if (IFID_VALID === 1'b1 && (prev_valid !== 1'b1 || IFID_PCADD4 !== prev_pcadd4)) begin
            if (exp_ifid_q.size() == 0) begin
                check("unexpected_ifid_entry", {IFID_ORDER, IFID_PCADD4}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("ifid_entry", {IFID_ORDER, IFID_PCADD4}, exp_ifid_q.pop_front());
            end
        end
        prev_valid  <= IFID_VALID;
        prev_pcadd4 <= IFID_PCADD4;
    end

    initial begin
        RESET             = 1'b0;
        IF_inPCWRITE      = 1'b1;
        IF_inIFIDWRITE    = 1'b1;
        IF_inPCSRC        = 1'b0;
        IF_inBADDRESS     = 32'h0;
        IF_inJUMP         = 2'b00;
        IF_inJUMPADDRESS  = 32'h0;
        IF_inRJUMP        = 2'b00;
        IF_inRJUMPADDRESS = 32'h0;
        IM_ACK            = 1'b0;
        IM_RDATA          = 32'h0;

        repeat (2) @(posedge CLOCK);
        #1;
        check("rst_im_req", {63'h0, IM_REQ}, 64'h0);
        check("rst_pc", {32'h0, IF_outPC}, 64'h0);
        check("rst_valid", {63'h0, IFID_VALID}, 64'h0);
        check("rst_order", {32'h0, IFID_ORDER}, 64'h0);
        check("rst_pcadd4", {32'h0, IFID_PCADD4}, 64'h0);
        RESET = 1'b1;
        #1;
        check("req_after_rst", {63'h0, IM_REQ}, 64'h1);

        // Back-to-back fetches
        fetch(32'h0, 32'h2008_0001);
        fetch(32'h4, 32'h2009_0002);
        fetch(32'h8, 32'h200A_0003);
        drive(1'b0, 32'h0);
        check("bubble_valid", {63'h0, IFID_VALID}, 64'h0);
        fetch(32'hC, 32'h0000_0020);

        // Decode stall while a fetch returns: held in skid buffer
        IF_inPCWRITE   = 1'b0;
        IF_inIFIDWRITE = 1'b0;
        exp_addr_q.push_back(32'h10);
        drive(1'b1, 32'h8D2A_0000);
        check("held_state", {62'h0, IF_outSTATE}, 64'h1);
        check("held_req", {63'h0, IM_REQ}, 64'h0);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("held_order", {32'h0, IFID_ORDER}, 64'h0000_0020);
        check("held_pc", {32'h0, IF_outPC}, 64'h10);
        IF_inPCWRITE   = 1'b1;
        IF_inIFIDWRITE = 1'b1;
        exp_ifid_q.push_back({32'h8D2A_0000, 32'h14});
        drive(1'b0, 32'h0);
        check("release_pc", {32'h0, IF_outPC}, 64'h14);
        fetch(32'h14, 32'h0123_4567);

        // Branch while fetch outstanding; late ACK discarded
        drive(1'b0, 32'h0);
        IF_inPCSRC    = 1'b1;
        IF_inBADDRESS = 32'h40;
        drive(1'b0, 32'h0);
        clear_redirects();
        check("br_pc", {32'h0, IF_outPC}, 64'h40);
        check("br_valid", {63'h0, IFID_VALID}, 64'h0);
        check("br_order", {32'h0, IFID_ORDER}, 64'h0);
        check("drain_state", {62'h0, IF_outSTATE}, 64'h2);
        check("drain_req", {63'h0, IM_REQ}, 64'h0);
        drive(1'b1, 32'hDEAD_BEEF);
        check("late_ack_valid", {63'h0, IFID_VALID}, 64'h0);
        fetch(32'h40, 32'h1111_1111);

        // Priority with a same-cycle ACK: RJUMP wins, ACK discarded
        IF_inRJUMP        = 2'b01;
        IF_inRJUMPADDRESS = 32'h100;
        IF_inJUMP         = 2'b10;
        IF_inJUMPADDRESS  = 32'h200;
        IF_inPCSRC        = 1'b1;
        IF_inBADDRESS     = 32'h40;
        exp_addr_q.push_back(32'h44);
        drive(1'b1, 32'h2222_2222);
        clear_redirects();
        check("prio_rjump_pc", {32'h0, IF_outPC}, 64'h100);
        check("prio_valid", {63'h0, IFID_VALID}, 64'h0);
        check("prio_state", {62'h0, IF_outSTATE}, 64'h0);
        fetch(32'h100, 32'h3333_3333);

        // JUMP beats PCSRC
        IF_inJUMP        = 2'b01;
        IF_inJUMPADDRESS = 32'h200;
        IF_inPCSRC       = 1'b1;
        IF_inBADDRESS    = 32'h80;
        drive(1'b0, 32'h0);
        clear_redirects();
        check("prio_jump_pc", {32'h0, IF_outPC}, 64'h200);
        drive(1'b1, 32'hBAD0_0001);
        fetch(32'h200, 32'h4444_4444);

        // Redirect ignored while PCWRITE=0
        IF_inPCWRITE  = 1'b0;
        IF_inPCSRC    = 1'b1;
        IF_inBADDRESS = 32'h80;
        drive(1'b0, 32'h0);
        clear_redirects();
        IF_inPCWRITE = 1'b1;
        check("nopcw_pc", {32'h0, IF_outPC}, 64'h204);
        check("nopcw_state", {62'h0, IF_outSTATE}, 64'h0);

        // PC+4 wraps to zero
        IF_inJUMP        = 2'b11;
        IF_inJUMPADDRESS = 32'hFFFF_FFFC;
        drive(1'b0, 32'h0);
        clear_redirects();
        check("wrap_target_pc", {32'h0, IF_outPC}, 64'hFFFF_FFFC);
        drive(1'b1, 32'hBAD0_0002);
        fetch(32'hFFFF_FFFC, 32'h5555_5555);
        check("wrap_pc", {32'h0, IF_outPC}, 64'h0);

        // Reset during an outstanding fetch
        fetch(32'h0, 32'h6666_6666);
        drive(1'b0, 32'h0);
        RESET = 1'b0;
        #1;
        check("midrst_req", {63'h0, IM_REQ}, 64'h0);
        IM_ACK   = 1'b1;
        IM_RDATA = 32'h7777_7777;
        @(posedge CLOCK);
        #1;
        IM_ACK = 1'b0;
        check("midrst_pc", {32'h0, IF_outPC}, 64'h0);
        check("midrst_valid", {63'h0, IFID_VALID}, 64'h0);
        check("midrst_pcadd4", {32'h0, IFID_PCADD4}, 64'h0);
        RESET = 1'b1;

        // Five fetches then two stall cycles
        fetch(32'h0, 32'h8888_0000);
        fetch(32'h4, 32'h8888_0001);
        fetch(32'h8, 32'h8888_0002);
        fetch(32'hC, 32'h8888_0003);
        fetch(32'h10, 32'h8888_0004);
        IF_inPCWRITE   = 1'b0;
        IF_inIFIDWRITE = 1'b0;
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("stall_hold_order", {32'h0, IFID_ORDER}, 64'h8888_0004);
        check("stall_hold_pc", {32'h0, IF_outPC}, 64'h14);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", {32'h0, IF_outFETCHCNT}, 64'd5);
        check("stall_cnt", {32'h0, IF_outSTALLCNT}, 64'd2);
`endif
        IF_inPCWRITE   = 1'b1;
        IF_inIFIDWRITE = 1'b1;
        drive(1'b0, 32'h0);
        @(negedge CLOCK);
        #1;
        check("addr_q_empty", 64'(exp_addr_q.size()), 64'h0);
        check("ifid_q_empty", 64'(exp_ifid_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
